// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: request inputs and redirect/flush/save outputs of the exception sequencer
interface exc_sequencer_if;
    logic        irq;
    logic        illop;
    logic        jr_k0;
    logic        branch_taken;
    logic        stall;
    logic [31:0] IF_ID_PC;
    logic        pcsrc_ovr_valid;
    logic [2:0]  pcsrc_ovr;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic        xp_write;
    logic [31:0] xp_data;
    logic        kernel;
    logic        irq_ack;
    logic        err;
    modport master (
        output irq, illop, jr_k0, branch_taken, stall, IF_ID_PC,
        input  pcsrc_ovr_valid, pcsrc_ovr, flush_IF_ID, flush_ID_EX, xp_write, xp_data, kernel, irq_ack, err
    );
    modport slave (
        input  irq, illop, jr_k0, branch_taken, stall, IF_ID_PC,
        output pcsrc_ovr_valid, pcsrc_ovr, flush_IF_ID, flush_ID_EX, xp_write, xp_data, kernel, irq_ack, err
    );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer: takes illop/irq into a kernel handler, saving the return PC in $26
module exc_sequencer (
    input  logic           clk,
    input  logic           reset,
    exc_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DEFER  = 3'd1;
    localparam logic [2:0] ENTER  = 3'd2;
    localparam logic [2:0] KERNEL = 3'd3;
    localparam logic [2:0] RETURN = 3'd4;
    logic [2:0]  state;
    logic        cause;
    logic        kernel_q;
    logic        err_q;
    logic [31:0] epc;
    logic        req;
    logic        blocked;
    logic        enter;
    assign req     = bus.illop | bus.irq;
    assign blocked = bus.branch_taken | bus.stall;
    assign enter   = state == ENTER;
    // sequencing, cause/epc capture on the way into ENTER, kernel and sticky err flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cause    <= 1'b0;
            kernel_q <= 1'b0;
            err_q    <= 1'b0;
            epc      <= 32'd0;
        end else begin
            err_q <= err_q | (bus.illop & kernel_q);
            case (state)
                IDLE, DEFER: begin
                    if (!req || kernel_q) state <= IDLE;
                    else if (blocked) state <= DEFER;
                    else begin
                        state <= ENTER;
                        cause <= bus.illop;
                        epc   <= bus.IF_ID_PC + (bus.illop ? 32'd4 : 32'd0);
                    end
                end
                ENTER: begin
                    state    <= KERNEL;
                    kernel_q <= 1'b1;
                end
                KERNEL: state <= (bus.jr_k0 && !bus.stall) ? RETURN : KERNEL;
                RETURN: begin
                    state    <= IDLE;
                    kernel_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.pcsrc_ovr_valid = enter;
    assign bus.pcsrc_ovr       = enter ? (cause ? 3'b100 : 3'b101) : 3'b000;
    assign bus.flush_IF_ID     = enter;
    assign bus.flush_ID_EX     = enter;
    assign bus.xp_write        = enter;
    assign bus.xp_data         = epc;
    assign bus.irq_ack         = enter & ~cause;
    assign bus.kernel          = kernel_q;
    assign bus.err             = err_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed literal checks plus randomized run against a behavioural model
module tb_exc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errs = 0;
    always #5 clk = ~clk;
    exc_sequencer_if bus();
    exc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    // model: only what is externally visible -- entering this cycle, in handler, leaving handler
    bit          armed = 1'b0;
    bit          m_ent, m_kern, m_leave, m_cause, m_err;
    bit          avail, nxt_ent, nxt_leave;
    logic [31:0] m_epc;
    always @(posedge clk) begin
        if (reset) begin
            armed = 1'b1;
            m_ent = 0; m_kern = 0; m_leave = 0; m_cause = 0; m_err = 0;
            m_epc = 32'd0;
        end else if (armed) begin
            avail   = !m_ent && !m_kern;
            nxt_ent = avail && (bus.irq || bus.illop) && !bus.branch_taken && !bus.stall;
            if (nxt_ent) begin
                m_cause = bus.illop;
                m_epc   = bus.IF_ID_PC + (bus.illop ? 32'd4 : 32'd0);
            end
            if (bus.illop && m_kern) m_err = 1;
            nxt_leave = m_kern && !m_leave && bus.jr_k0 && !bus.stall;
            if (m_ent) m_kern = 1;
            else if (m_leave) m_kern = 0;
            m_ent   = nxt_ent;
            m_leave = nxt_leave;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle after the first reset: compare all outputs to the model
    always @(negedge clk) begin
        if (armed) begin
            chk("m.valid", 32'(bus.pcsrc_ovr_valid), 32'(m_ent));
            chk("m.pcsrc", 32'(bus.pcsrc_ovr), m_ent ? (m_cause ? 32'd4 : 32'd5) : 32'd0);
            chk("m.fl_if", 32'(bus.flush_IF_ID), 32'(m_ent));
            chk("m.fl_id", 32'(bus.flush_ID_EX), 32'(m_ent));
            chk("m.xpw", 32'(bus.xp_write), 32'(m_ent));
            chk("m.xpd", bus.xp_data, m_epc);
            chk("m.ack", 32'(bus.irq_ack), 32'(m_ent && !m_cause));
            chk("m.kernel", 32'(bus.kernel), 32'(m_kern));
            chk("m.err", 32'(bus.err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.irq = 0; bus.illop = 0; bus.jr_k0 = 0; bus.branch_taken = 0; bus.stall = 0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        bus.IF_ID_PC = 32'd0;
        cyc(); cyc();
        chk("rst.valid", 32'(bus.pcsrc_ovr_valid), 32'd0);
        chk("rst.kernel", 32'(bus.kernel), 32'd0);
        chk("rst.xpd", bus.xp_data, 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        bus.irq = 1; bus.IF_ID_PC = 32'h0040_0010;
        cyc();
        chk("irq.valid", 32'(bus.pcsrc_ovr_valid), 32'd1);
        chk("irq.pcsrc", 32'(bus.pcsrc_ovr), 32'd5);
        chk("irq.flush", 32'({bus.flush_IF_ID, bus.flush_ID_EX}), 32'd3);
        chk("irq.xpw", 32'(bus.xp_write), 32'd1);
        chk("irq.xpd", bus.xp_data, 32'h0040_0010);
        chk("irq.ack", 32'(bus.irq_ack), 32'd1);
        bus.irq = 0;
        cyc();
        chk("irq.kernel", 32'(bus.kernel), 32'd1);
        bus.irq = 1;
        cyc();
        chk("k.irq_ign", 32'(bus.pcsrc_ovr_valid), 32'd0);
        bus.irq = 0; bus.illop = 1;
        cyc();
        chk("k.err", 32'(bus.err), 32'd1);
        chk("k.noflush", 32'(bus.flush_IF_ID), 32'd0);
        bus.illop = 0; bus.irq = 1; bus.jr_k0 = 1;
        cyc();
        chk("ret.kernel", 32'(bus.kernel), 32'd1);
        chk("ret.valid", 32'(bus.pcsrc_ovr_valid), 32'd0);
        bus.jr_k0 = 0;
        cyc();
        chk("idle.kernel", 32'(bus.kernel), 32'd0);
        cyc();
        chk("held.valid", 32'(bus.pcsrc_ovr_valid), 32'd1);
        chk("held.ack", 32'(bus.irq_ack), 32'd1);
        bus.irq = 0;
        cyc(); bus.jr_k0 = 1; cyc(); bus.jr_k0 = 0; cyc();
        bus.illop = 1; bus.irq = 1; bus.IF_ID_PC = 32'h0040_0020;
        cyc();
        chk("both.pcsrc", 32'(bus.pcsrc_ovr), 32'd4);
        chk("both.xpd", bus.xp_data, 32'h0040_0024);
        chk("both.ack", 32'(bus.irq_ack), 32'd0);
        clr();
        cyc(); bus.jr_k0 = 1; cyc(); bus.jr_k0 = 0; cyc();
        bus.irq = 1; bus.branch_taken = 1; bus.IF_ID_PC = 32'h0040_0050;
        cyc();
        chk("defer.valid", 32'(bus.pcsrc_ovr_valid), 32'd0);
        bus.branch_taken = 0; bus.IF_ID_PC = 32'h0040_0100;
        cyc();
        chk("defer.enter", 32'(bus.pcsrc_ovr_valid), 32'd1);
        chk("defer.xpd", bus.xp_data, 32'h0040_0100);
        bus.irq = 0;
        cyc(); bus.jr_k0 = 1; cyc(); bus.jr_k0 = 0; cyc();
        bus.irq = 1; bus.stall = 1;
        cyc();
        clr();
        cyc();
        chk("drop.valid", 32'(bus.pcsrc_ovr_valid), 32'd0);
        cyc();
        chk("drop.idle", 32'(bus.pcsrc_ovr_valid), 32'd0);
        bus.irq = 1; bus.IF_ID_PC = 32'h0040_0200;
        cyc();
        chk("pre_rst.valid", 32'(bus.pcsrc_ovr_valid), 32'd1);
        reset = 1; bus.irq = 0;
        cyc();
        chk("mid_rst.valid", 32'(bus.pcsrc_ovr_valid), 32'd0);
        chk("mid_rst.kernel", 32'(bus.kernel), 32'd0);
        chk("mid_rst.err", 32'(bus.err), 32'd0);
        chk("mid_rst.xpd", bus.xp_data, 32'd0);
        reset = 0;
        cyc();
        chk("post_rst.kernel", 32'(bus.kernel), 32'd0);
        bus.illop = 1; bus.IF_ID_PC = 32'hFFFF_FFFC;
        cyc();
        chk("wrap.xpd", bus.xp_data, 32'd0);
        chk("wrap.pcsrc", 32'(bus.pcsrc_ovr), 32'd4);
        clr();
        cyc();
        for (int i = 0; i < 3000; i++) begin
            reset            = $urandom_range(99) == 0;
            bus.irq          = $urandom_range(99) < 30;
            bus.illop        = $urandom_range(99) < 10;
            bus.jr_k0        = $urandom_range(99) < 25;
            bus.branch_taken = $urandom_range(99) < 25;
            bus.stall        = $urandom_range(99) < 25;
            bus.IF_ID_PC     = $urandom_range(15) == 0 ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
            cyc();
        end
        reset = 0;
        clr();
        cyc();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
